// File: rtl/cache_way_ctrl.sv
// ---------------------------------------------------------------------------
// cache_way_ctrl
//
// Per-access way selection and miss handling for an N-way set-associative
// cache. Sits directly upstream of the pLRU tree: it consumes the tree's
// victim way (plru) and produces the tree's update inputs (load, index,
// last_access). It also drives the data/tag array write enables and the
// physical-memory handshake for writeback and line fill.
//
// Optional build macro:
//   CACHE_PERF_CNT_EN  adds hit_count / miss_count performance counters.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   mem_read     CPU read request, held until mem_resp
//   mem_write    CPU write request, held until mem_resp
//   set_idx      set index of the current request
//   hit_vec      per-way tag match (already qualified by valid)
//   valid_vec    valid bits of the addressed set
//   dirty_vec    dirty bits of the addressed set
//   plru         victim way from the pLRU tree
//   pmem_resp    physical memory done, 1-cycle pulse
//   mem_resp     CPU response, 1-cycle pulse
//   pmem_read    physical memory line read request (fill)
//   pmem_write   physical memory line writeback request
//   way_sel      way addressed by the array / pmem datapath
//   index        latched set index to pLRU tree and arrays
//   load         pLRU update strobe
//   last_access  way just accessed, to the pLRU tree
//   fill_we      data+tag array write for a line fill
//   valid_set    set valid bit of way_sel
//   dirty_set    set dirty bit of way_sel (CPU write)
//   dirty_clr    clear dirty bit of way_sel (fill)
//   hit_count    (CACHE_PERF_CNT_EN only) accepted hits, wraps
//   miss_count   (CACHE_PERF_CNT_EN only) accepted misses, wraps
// ---------------------------------------------------------------------------
module cache_way_ctrl #(
    parameter int WAYS  = 8,
    parameter int WAY_W = 3,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAY_W-1:0] plru,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [WAY_W-1:0] way_sel,
    output logic [IDX_W-1:0] index,
    output logic             load,
    output logic [WAY_W-1:0] last_access,
    output logic             fill_we,
    output logic             valid_set,
    output logic             dirty_set,
    output logic             dirty_clr
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WAY_W-1:0] way_reg;
    logic [WAY_W-1:0] way_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic             wr_reg;
    logic             wr_next;

    // -----------------------------------------------------------------------
    // Way selection
    //
    // Lowest set bit is isolated arithmetically (x & -x), then the one-hot
    // vector is turned into a way number with an OR of per-way terms.
    // -----------------------------------------------------------------------
    logic             req;
    logic             accept;
    logic             is_hit;
    logic             any_invalid;
    logic [WAYS-1:0]  invalid_vec;
    logic [WAYS-1:0]  hit_oh;
    logic [WAYS-1:0]  inv_oh;
    logic [WAY_W-1:0] hit_terms [WAYS];
    logic [WAY_W-1:0] inv_terms [WAYS];
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_dirty;

    assign req         = mem_read | mem_write;
    assign accept      = (state_reg == ST_IDLE) && req;
    assign is_hit      = |hit_vec;
    assign invalid_vec = ~valid_vec;
    assign any_invalid = |invalid_vec;
    assign hit_oh      = hit_vec & (~hit_vec + {{(WAYS-1){1'b0}}, 1'b1});
    assign inv_oh      = invalid_vec & (~invalid_vec + {{(WAYS-1){1'b0}}, 1'b1});

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_enc
            assign hit_terms[gi] = hit_oh[gi] ? WAY_W'(gi) : '0;
            assign inv_terms[gi] = inv_oh[gi] ? WAY_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            hit_way = hit_way | hit_terms[i];
            inv_way = inv_way | inv_terms[i];
        end
    end

    // An empty way always wins over the pLRU choice; only a valid victim
    // can carry dirty data that needs writing back.
    assign victim_way   = any_invalid ? inv_way : plru;
    assign victim_dirty = valid_vec[victim_way] & dirty_vec[victim_way];

    // -----------------------------------------------------------------------
    // Next-state and latch logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        way_next   = way_reg;
        idx_next   = idx_reg;
        wr_next    = wr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    idx_next = set_idx;
                    // A simultaneous read and write is handled as a write.
                    wr_next  = mem_write;
                    if (is_hit) begin
                        way_next   = hit_way;
                        state_next = ST_RESP;
                    end else begin
                        way_next   = victim_way;
                        state_next = victim_dirty ? ST_WB : ST_FILL;
                    end
                end
            end
            ST_WB: begin
                if (pmem_resp) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                // The fill completes even if the CPU dropped its request.
                if (pmem_resp) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // No accept here: a held request is re-evaluated from IDLE.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            way_reg   <= '0;
            idx_reg   <= '0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            way_reg   <= way_next;
            idx_reg   <= idx_next;
            wr_reg    <= wr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all decoded from the state register, so reset forces them low
    // immediately and an interrupted fill never produces fill_we)
    // -----------------------------------------------------------------------
    logic fill_done;

    assign fill_done = (state_reg == ST_FILL) && pmem_resp;

    always_comb begin
        mem_resp    = 1'b0;
        load        = 1'b0;
        last_access = '0;
        dirty_set   = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        way_sel     = '0;
        case (state_reg)
            ST_WB: begin
                pmem_write = 1'b1;
                way_sel    = way_reg;
            end
            ST_FILL: begin
                pmem_read = 1'b1;
                way_sel   = way_reg;
            end
            ST_RESP: begin
                mem_resp    = 1'b1;
                load        = 1'b1;
                last_access = way_reg;
                dirty_set   = wr_reg;
                way_sel     = way_reg;
            end
            default: begin
                way_sel = '0;
            end
        endcase
    end

    assign index     = idx_reg;
    assign fill_we   = fill_done;
    assign valid_set = fill_done;
    assign dirty_clr = fill_done;

`ifdef CACHE_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counters: one count per accepted request, free-running wrap
    // -----------------------------------------------------------------------
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (accept) begin
            if (is_hit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end else begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_cache_way_ctrl.sv
module tb_cache_way_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read, mem_write;
    logic [2:0] set_idx;
    logic [7:0] hit_vec, valid_vec, dirty_vec;
    logic [2:0] plru;
    logic       pmem_resp;
    logic       mem_resp, pmem_read, pmem_write;
    logic [2:0] way_sel, index, last_access;
    logic       load, fill_we, valid_set, dirty_set, dirty_clr;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_way_ctrl #(.WAYS(8), .WAY_W(3), .IDX_W(3)) dut (
        .clk(clk), .rst(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .set_idx(set_idx),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .plru(plru), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .way_sel(way_sel), .index(index), .load(load),
        .last_access(last_access), .fill_we(fill_we), .valid_set(valid_set),
        .dirty_set(dirty_set), .dirty_clr(dirty_clr)
`ifdef CACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] way;
        logic       dirty;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] w, input logic d, input logic [2:0] i);
        exp_t e;
        e.way = w; e.dirty = d; e.idx = i;
        sb.push_back(e);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_resp"}, 32'(mem_resp), 32'd0);
        chk({tag, "_pmem"}, 32'({pmem_read, pmem_write}), 32'd0);
        chk({tag, "_fill_we"}, 32'({fill_we, valid_set, dirty_clr}), 32'd0);
        chk({tag, "_way_sel"}, 32'(way_sel), 32'd0);
        chk({tag, "_load"}, 32'({load, last_access, dirty_set}), 32'd0);
    endtask

    // Waits (bounded) for mem_resp, pops the scoreboard and compares, then
    // drops the request and steps back to IDLE.
    task automatic wait_resp(input int exp_lat);
        int   n = 0;
        exp_t e;
        while (!mem_resp && n < 20) begin
            tick();
            n++;
        end
        chk("resp_seen", 32'(mem_resp), 32'd1);
        if (mem_resp) begin
            chk("resp_latency", 32'(n), 32'(exp_lat));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("last_access", 32'(last_access), 32'(e.way));
                chk("dirty_set", 32'(dirty_set), 32'(e.dirty));
                chk("index", 32'(index), 32'(e.idx));
                chk("load", 32'(load), 32'd1);
                chk("resp_pmem", 32'({pmem_read, pmem_write}), 32'd0);
                $display("txn %0d: way=%0d idx=%0d dirty_set=%0d latency=%0d",
                         txn, last_access, index, dirty_set, n);
            end else begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end
        end
        txn++;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 0; mem_write = 0; set_idx = 0;
        hit_vec = 0; valid_vec = 0; dirty_vec = 0; plru = 0; pmem_resp = 0;
        #1;
        chk_idle_outputs("reset");
        chk("reset_index", 32'(index), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_idle_outputs("post_reset");

        // Read hit on way 5, set 5
        mem_read = 1; set_idx = 3'd5; hit_vec = 8'b0010_0000; valid_vec = 8'hFF;
        push_exp(3'd5, 1'b0, 3'd5); exp_hits++;
        wait_resp(1);

        // Read miss: invalid way 3 beats plru 6
        mem_read = 1; set_idx = 3'd2; hit_vec = 0; valid_vec = 8'b1111_0111; plru = 3'd6;
        push_exp(3'd3, 1'b0, 3'd2); exp_misses++;
        chk("miss_detect_load", 32'(load), 32'd0);
        tick();
        chk("fill_pmem_read", 32'(pmem_read), 32'd1);
        chk("fill_pmem_write", 32'(pmem_write), 32'd0);
        chk("fill_way_sel", 32'(way_sel), 32'd3);
        chk("fill_load", 32'(load), 32'd0);
        chk("fill_early_we", 32'(fill_we), 32'd0);
        tick(); tick(); tick();
        pmem_resp = 1; #1;
        chk("fill_we", 32'({fill_we, valid_set, dirty_clr}), 32'h7);
        chk("fill_we_way", 32'(way_sel), 32'd3);
        tick();
        pmem_resp = 0;
        wait_resp(0);

        // Write miss, dirty victim from pLRU -> writeback then fill
        mem_write = 1; set_idx = 3'd7; valid_vec = 8'hFF; dirty_vec = 8'b0000_0100; plru = 3'd2;
        push_exp(3'd2, 1'b1, 3'd7); exp_misses++;
        tick();
        chk("wb_pmem_write", 32'(pmem_write), 32'd1);
        chk("wb_pmem_read", 32'(pmem_read), 32'd0);
        chk("wb_way_sel", 32'(way_sel), 32'd2);
        tick();
        pmem_resp = 1; #1;
        chk("wb_no_fill_we", 32'(fill_we), 32'd0);
        tick();
        pmem_resp = 0;
        chk("wb2fill_read", 32'({pmem_read, pmem_write}), 32'b10);
        tick();
        pmem_resp = 1; #1;
        chk("wb_fill_we", 32'(fill_we), 32'd1);
        tick();
        pmem_resp = 0; dirty_vec = 0;
        wait_resp(0);

        // Clean miss with all ways valid: plru victim, no writeback
        mem_read = 1; set_idx = 3'd1; valid_vec = 8'hFF; dirty_vec = 8'b1011_1111; plru = 3'd6;
        push_exp(3'd6, 1'b0, 3'd1); exp_misses++;
        tick();
        chk("clean_pmem", 32'({pmem_read, pmem_write}), 32'b10);
        chk("clean_way_sel", 32'(way_sel), 32'd6);
        pmem_resp = 1;
        tick();
        pmem_resp = 0; dirty_vec = 0;
        wait_resp(0);

        // Request dropped mid-fill still completes and responds
        mem_read = 1; set_idx = 3'd0; valid_vec = 8'b0001_1111;
        push_exp(3'd5, 1'b0, 3'd0); exp_misses++;
        tick();
        mem_read = 0;
        tick();
        chk("drop_still_fill", 32'(pmem_read), 32'd1);
        pmem_resp = 1;
        tick();
        pmem_resp = 0;
        wait_resp(0);

`ifdef CACHE_PERF_CNT_EN
        chk("hit_count", hit_count, 32'(exp_hits));
        chk("miss_count", miss_count, 32'(exp_misses));
`endif

        // Reset asserted mid-fill
        mem_read = 1; set_idx = 3'd4; valid_vec = 8'b1111_1110; hit_vec = 0;
        tick();
        chk("pre_rst_read", 32'(pmem_read), 32'd1);
        rst_n = 0; pmem_resp = 1; #1;
        chk_idle_outputs("mid_fill_rst");
        chk("rst_index", 32'(index), 32'd0);
        exp_hits = 0; exp_misses = 0;
        mem_read = 0;
        tick();
        pmem_resp = 0; rst_n = 1;
        tick();
        chk_idle_outputs("after_rst");

        // Read hit on way 0 after reset
        mem_read = 1; set_idx = 3'd1; hit_vec = 8'b0000_0001; valid_vec = 8'hFF;
        push_exp(3'd0, 1'b0, 3'd1); exp_hits++;
        wait_resp(1);

        // Stray pmem_resp in IDLE is ignored
        pmem_resp = 1;
        tick();
        pmem_resp = 0;
        chk_idle_outputs("stray_pmem");

        // Multi-hit picks lowest way
        mem_read = 1; set_idx = 3'd3; hit_vec = 8'b1000_0010;
        push_exp(3'd1, 1'b0, 3'd3); exp_hits++;
        wait_resp(1);

        // Read and write together act as a write
        mem_read = 1; mem_write = 1; set_idx = 3'd6; hit_vec = 8'b0001_0000;
        push_exp(3'd4, 1'b1, 3'd6); exp_hits++;
        wait_resp(1);

`ifdef CACHE_PERF_CNT_EN
        chk("hit_count_post_rst", hit_count, 32'(exp_hits));
        chk("miss_count_post_rst", miss_count, 32'(exp_misses));
        force dut.hit_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.hit_count_reg;
        mem_read = 1; set_idx = 3'd2; hit_vec = 8'b0000_0100;
        push_exp(3'd2, 1'b0, 3'd2);
        wait_resp(1);
        chk("hit_count_wrap", hit_count, 32'd0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_way_ctrl.md
Name: cache_way_ctrl

Overview:
Per-access way-selection and miss-handling controller for the 8-way set-associative cache. It sits directly upstream of the pLRU tree: it consumes the tree's `plru` victim output and produces the tree's `load`, `index` and `last_access` update inputs. It also drives the data/tag array write enables and the physical-memory handshake for writeback and fill.

Parameters:
WAYS, 8, number of ways (power of 2)
WAY_W, 3, log2(WAYS); width of way numbers
IDX_W, 3, set index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
set_idx  in  IDX_W  set index of current request
hit_vec  in  WAYS  per-way tag match (already qualified by valid)
valid_vec  in  WAYS  valid bits of addressed set
dirty_vec  in  WAYS  dirty bits of addressed set
plru  in  WAY_W  victim way from pLRU tree
pmem_resp  in  1  physical memory done, 1-cycle pulse
mem_resp  out  1  CPU response, 1-cycle pulse
pmem_read  out  1  physical memory line read request
pmem_write  out  1  physical memory line writeback request
way_sel  out  WAY_W  way addressed by array/pmem datapath
index  out  IDX_W  latched set index to pLRU tree and arrays
load  out  1  pLRU update strobe
last_access  out  WAY_W  way just accessed, to pLRU tree
fill_we  out  1  data+tag array write for line fill
valid_set  out  1  set valid bit of way_sel
dirty_set  out  1  set dirty bit of way_sel (CPU write)
dirty_clr  out  1  clear dirty bit of way_sel (fill)

Behaviour:
- States: IDLE, WB, FILL, RESP. Encoding is free; the state register is reset asynchronously to IDLE while rst=0.
- Reset values: all outputs are 0, latched way is 0, latched index is 0.
- IDLE:
  - On a clock edge with (mem_read|mem_write)=1, latch set_idx into index.
  - Hit (hit_vec != 0): latch way = lowest set bit of hit_vec. Go to RESP.
  - Miss: victim = lowest-index way with valid_vec=0 if any exists; otherwise victim = plru. Latch it into way.
  - Miss with a valid, dirty victim goes to WB; any other miss goes to FILL.
- WB: pmem_write=1, way_sel=way. On pmem_resp go to FILL.
- FILL: pmem_read=1. In the cycle pmem_resp=1, fill_we=valid_set=dirty_clr=1 (combinational on pmem_resp). Then go to RESP.
- RESP (exactly one cycle):
  - mem_resp=1, load=1, last_access=way.
  - dirty_set = latched write flag (mem_write sampled at accept).
  - Next state is IDLE.
- way_sel equals the latched way in every state except IDLE, where it is 0.
- Latency:
  - Hit: request at edge N gives mem_resp in cycle N+1.
  - Clean miss: mem_resp 1 cycle after the fill pmem_resp.
  - Dirty miss: adds the full writeback handshake before the fill.
- Edge cases:
  - pmem_resp in IDLE or RESP is ignored.
  - A request dropped mid-miss still completes the fill and still pulses mem_resp.
  - No new request is accepted in RESP; a held request is re-evaluated in IDLE on the next edge, which makes it a hit.
  - Reset asserted mid-WB/FILL: pmem_read/pmem_write fall immediately and the transaction is abandoned. No partial fill_we is issued.
  - mem_read and mem_write both high is treated as a write.
  - load is asserted only in RESP, never on a miss-detect cycle.

Optional Feature:
Macro CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Both reset asynchronously to 0.
  - hit_count increments on each IDLE accept that hits; miss_count increments on each IDLE accept that misses.
  - Both wrap at 2^32-1 to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Read hit, hit_vec=8'b0010_0000, set_idx=5 -> next cycle: mem_resp=1, load=1, last_access=5, index=5, no pmem activity.
- Read miss, valid_vec=8'b1111_0111, plru=6 -> victim 3 (invalid way wins). FILL: pmem_read=1; pmem_resp after 4 cycles -> fill_we/valid_set/dirty_clr with way_sel=3. Next cycle: mem_resp=1, last_access=3.
- Write miss, all valid, dirty_vec[2]=1, plru=2 -> pmem_write=1, way_sel=2. pmem_resp -> pmem_read=1. pmem_resp -> fill. RESP: dirty_set=1, last_access=2.
- Reset (rst=0) mid-FILL with pmem_read=1 -> all outputs 0 immediately. After release, a read hit on way 0 responds normally in 1 cycle.
- Stray pmem_resp in IDLE, and hit_vec=8'b1000_0010 -> no state change; then a hit selects way 1 (lowest bit).
- With CACHE_PERF_CNT_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2. Preload hit_count=32'hFFFF_FFFF, one hit -> 0.
